// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronises and debounces a raw push-button, emitting a
//   one-cycle press pulse, a debounced level and a one-shot long-press pulse.
// Latency: press/release confirmed DEBOUNCE_CYCLES+2 edges after first sample.
// Backpressure: none; free-running conditioning stage with no handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   btn_raw    in   raw asynchronous button, active-high
//   btn_pulse  out  one cycle per confirmed press
//   long_pulse out  one cycle, at most once per press, after LONG_CYCLES hold
//   btn_level  out  debounced button level
//   state_dbg  out  FSM state code (00 idle, 01 press wait, 11 pressed, 10 release wait)
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_pulse,
  output logic       long_pulse,
  output logic       btn_level,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             w_btn_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_long_done;
  logic             r_btn_pulse;
  logic             r_long_pulse;
  logic             r_btn_level;
  logic             w_confirm;
  logic             w_release;
  logic             w_dcnt_inc;
  logic             w_holding;
  logic             w_long_hit;

  // Two-flop synchroniser; only the second stage feeds the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= btn_raw;
      r_sync1 <= r_sync0;
    end
  end

  assign w_btn_s = r_sync1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_confirm   = 1'b0;
    w_release   = 1'b0;
    w_dcnt_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_btn_s) w_state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt = PRESSED;
          w_confirm   = 1'b1;
        end else begin
          w_dcnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        if (!w_btn_s) w_state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end else begin
          w_dcnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Hold time accrues while the debounced level is high, including the
  // release window, so a bouncy release does not restart the long count.
  assign w_holding  = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
  assign w_long_hit = w_holding && !r_long_done && (r_hcnt == LONG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dcnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_dcnt <= '0;
    end else if (w_dcnt_inc) begin
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  // hcnt freezes once the threshold is hit; long_done blocks re-firing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt      <= '0;
      r_long_done <= 1'b0;
    end else if (w_confirm) begin
      r_hcnt      <= '0;
      r_long_done <= 1'b0;
    end else if (w_long_hit) begin
      r_long_done <= 1'b1;
    end else if (w_holding && !r_long_done) begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_pulse  <= 1'b0;
      r_long_pulse <= 1'b0;
      r_btn_level  <= 1'b0;
    end else begin
      r_btn_pulse  <= w_confirm;
      r_long_pulse <= w_long_hit;
      if (w_confirm) begin
        r_btn_level <= 1'b1;
      end else if (w_release) begin
        r_btn_level <= 1'b0;
      end
    end
  end

  assign btn_pulse  = r_btn_pulse;
  assign long_pulse = r_long_pulse;
  assign btn_level  = r_btn_level;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: directed scenarios plus randomized bounce traffic for
//   btn_debounce_pulse, checked against a run-length reference model.
// Ports: none (top-level bench).
module tb_btn_debounce_pulse;

  localparam int D = 4;
  localparam int L = 10;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_raw = 1'b0;
  logic       btn_pulse;
  logic       long_pulse;
  logic       btn_level;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .CNT_W          (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse),
    .long_pulse(long_pulse),
    .btn_level (btn_level),
    .state_dbg (state_dbg)
  );

  // Reference model: the debounced level flips when the synchronised input
  // has been sampled at the opposite value on D+1 consecutive edges; hold
  // time is the number of edges seen with the level high since it rose.
  logic m_s0 = 1'b0, m_s1 = 1'b0, m_last = 1'b0;
  logic m_level = 1'b0, m_pulse = 1'b0, m_long = 1'b0, m_lvl_was = 1'b0;
  int   run0 = 0, run1 = 0, hold = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s0 = 1'b0; m_s1 = 1'b0; m_last = 1'b0;
      m_level = 1'b0; m_pulse = 1'b0; m_long = 1'b0;
      run0 = 0; run1 = 0; hold = 0;
    end else begin
      m_last    = m_s1;
      m_lvl_was = m_level;
      m_pulse   = 1'b0;
      m_long    = 1'b0;
      if (m_last) begin run1++; run0 = 0; end
      else        begin run0++; run1 = 0; end
      if (m_lvl_was) begin
        hold++;
        if (hold == L) m_long = 1'b1;
      end
      if (!m_lvl_was && run1 == D + 1) begin
        m_level = 1'b1;
        m_pulse = 1'b1;
        hold    = 0;
      end else if (m_lvl_was && run0 == D + 1) begin
        m_level = 1'b0;
      end
      m_s1 = m_s0;
      m_s0 = btn_raw;
    end
  end

  // Drive one input value across the next rising edge; returns at the
  // following falling edge so outputs are sampled mid-cycle.
  task automatic cyc(input logic b);
    btn_raw = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset   = 1'b1;
    btn_raw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    total++; if (btn_pulse !== 1'b0) begin bad++; $display("FAIL reset.btn_pulse got=%b want=0", btn_pulse); end
    total++; if (long_pulse !== 1'b0) begin bad++; $display("FAIL reset.long_pulse got=%b want=0", long_pulse); end
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL reset.btn_level got=%b want=0", btn_level); end
    total++; if (state_dbg !== 2'b00) begin bad++; $display("FAIL reset.state_dbg got=%b want=00", state_dbg); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) cyc(1'b0);
    total++; if (state_dbg !== 2'b00) begin bad++; $display("FAIL reset.idle_state got=%b want=00", state_dbg); end
  endtask

  // Held press: pulse after E6, long pulse after E16.
  task automatic test_long_hold();
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      cyc(1'b1);
      total++; if (btn_pulse !== (k == 6)) begin bad++; $display("FAIL long_hold.btn_pulse k=%0d got=%b want=%b", k, btn_pulse, k == 6); end
      total++; if (long_pulse !== (k == 16)) begin bad++; $display("FAIL long_hold.long_pulse k=%0d got=%b want=%b", k, long_pulse, k == 16); end
      total++; if (btn_level !== (k >= 6)) begin bad++; $display("FAIL long_hold.btn_level k=%0d got=%b want=%b", k, btn_level, k >= 6); end
    end
    total++; if (state_dbg !== 2'b11) begin bad++; $display("FAIL long_hold.state got=%b want=11", state_dbg); end
  endtask

  // Too-short press is rejected.
  task automatic test_short_press();
    logic seen01 = 1'b0;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(k < 3);
      if (state_dbg == 2'b01) seen01 = 1'b1;
      total++; if (btn_pulse !== 1'b0) begin bad++; $display("FAIL short.btn_pulse k=%0d got=%b want=0", k, btn_pulse); end
      total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL short.btn_level k=%0d got=%b want=0", k, btn_level); end
    end
    total++; if (seen01 !== 1'b1) begin bad++; $display("FAIL short.visit01 got=%b want=1", seen01); end
    total++; if (state_dbg !== 2'b00) begin bad++; $display("FAIL short.final_state got=%b want=00", state_dbg); end
  endtask

  // Brief release glitch while pressed returns to PRESSED.
  task automatic test_release_bounce();
    logic seen10 = 1'b0;
    apply_reset();
    for (int k = 0; k < 10; k++) cyc(1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(k >= 2);
      if (state_dbg == 2'b10) seen10 = 1'b1;
      total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL rel_bounce.btn_level k=%0d got=%b want=1", k, btn_level); end
      total++; if (btn_pulse !== 1'b0) begin bad++; $display("FAIL rel_bounce.btn_pulse k=%0d got=%b want=0", k, btn_pulse); end
    end
    total++; if (seen10 !== 1'b1) begin bad++; $display("FAIL rel_bounce.visit10 got=%b want=1", seen10); end
    total++; if (state_dbg !== 2'b11) begin bad++; $display("FAIL rel_bounce.final_state got=%b want=11", state_dbg); end
  endtask

  // Clean release from PRESSED (long pulse already spent during the hold).
  task automatic test_release();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0);
      total++; if (btn_level !== (k < 6)) begin bad++; $display("FAIL release.btn_level k=%0d got=%b want=%b", k, btn_level, k < 6); end
      total++; if (btn_pulse !== 1'b0) begin bad++; $display("FAIL release.btn_pulse k=%0d got=%b want=0", k, btn_pulse); end
      total++; if (long_pulse !== 1'b0) begin bad++; $display("FAIL release.long_pulse k=%0d got=%b want=0", k, long_pulse); end
    end
    total++; if (state_dbg !== 2'b00) begin bad++; $display("FAIL release.final_state got=%b want=00", state_dbg); end
  endtask

  // Short hold released before the long threshold, then a second press.
  // Release debounces at E14, before the long threshold at E16.
  task automatic test_second_press();
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      cyc((k < 8) || (k >= 20));
      total++; if (btn_pulse !== (k == 6 || k == 26)) begin bad++; $display("FAIL second.btn_pulse k=%0d got=%b want=%b", k, btn_pulse, k == 6 || k == 26); end
      total++; if (long_pulse !== 1'b0) begin bad++; $display("FAIL second.long_pulse k=%0d got=%b want=0", k, long_pulse); end
      total++; if (btn_level !== ((k >= 6 && k < 14) || k >= 26)) begin bad++; $display("FAIL second.btn_level k=%0d got=%b want=%b", k, btn_level, (k >= 6 && k < 14) || k >= 26); end
    end
  endtask

  // Asynchronous reset in PRESS_WAIT, then a fresh full-latency press.
  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1);
    total++; if (state_dbg !== 2'b01) begin bad++; $display("FAIL rst_mid.pre_state got=%b want=01", state_dbg); end
    reset = 1'b1;
    #1;
    total++; if (state_dbg !== 2'b00) begin bad++; $display("FAIL rst_mid.state got=%b want=00", state_dbg); end
    total++; if ({btn_pulse, long_pulse, btn_level} !== 3'b000) begin bad++; $display("FAIL rst_mid.outputs got=%b want=000", {btn_pulse, long_pulse, btn_level}); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1);
      total++; if (btn_pulse !== (k == 6)) begin bad++; $display("FAIL rst_mid.btn_pulse k=%0d got=%b want=%b", k, btn_pulse, k == 6); end
      total++; if (btn_level !== (k >= 6)) begin bad++; $display("FAIL rst_mid.btn_level k=%0d got=%b want=%b", k, btn_level, k >= 6); end
    end
  endtask

  // Random bounce segments and occasional resets against the model.
  task automatic test_random();
    int   n = 0;
    int   len;
    logic val;
    apply_reset();
    while (n < 4000) begin
      val = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(D + 2, 3 * L);
      else                           len = $urandom_range(1, D + 2);
      for (int i = 0; i < len; i++) begin
        cyc(val);
        n++;
        total++;
        if ({btn_pulse, long_pulse, btn_level, state_dbg} !== {m_pulse, m_long, m_level, m_level, m_last}) begin
          bad++;
          $display("FAIL random.outputs n=%0d got(p,l,lvl,st)=%b want=%b", n, {btn_pulse, long_pulse, btn_level, state_dbg}, {m_pulse, m_long, m_level, m_level, m_last});
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        total++;
        if ({btn_pulse, long_pulse, btn_level, state_dbg} !== 5'b00000) begin
          bad++;
          $display("FAIL random.reset n=%0d got=%b want=00000", n, {btn_pulse, long_pulse, btn_level, state_dbg});
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_long_hold();
    test_short_press();
    test_release_bounce();
    test_release();
    test_second_press();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Front-end conditioning stage for a mechanical push-button. It synchronises the raw asynchronous input, debounces it in both directions with a programmable stability window, and emits a single-cycle `btn_pulse` per confirmed press. That pulse drives the `btn` input of the light-toggle FSM, so each physical press toggles the light exactly once. It also provides a debounced level, a one-shot long-press pulse and a debug state code.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: cycles the synchronised input must be stable to confirm a press or release; must be at least 2.
- `LONG_CYCLES`, default 25000000: hold cycles, counted from press confirmation, before `long_pulse` fires; must be at least 1.
- `CNT_W`, default 26: width of both counters; `DEBOUNCE_CYCLES` and `LONG_CYCLES` must each be at most 2^CNT_W − 1.
- `clk` in, 1: system clock, all logic on rising edge.
- `reset` in, 1: asynchronous, active-high.
- `btn_raw` in, 1: raw button, asynchronous, active-high.
- `btn_pulse` out, 1: registered; high for exactly one cycle per confirmed press.
- `long_pulse` out, 1: registered; high for one cycle, at most once per press.
- `btn_level` out, 1: registered debounced level.
- `state_dbg` out, 2: current FSM state code.

## Operation
- **Synchroniser:** 2-flop synchroniser on `btn_raw`. Its second-stage output `btn_s` is the only value the FSM uses.
- **FSM states and codes:**
  - IDLE = 00
  - PRESS_WAIT = 01
  - PRESSED = 11
  - RELEASE_WAIT = 10
- **Debounce counter `dcnt`** (CNT_W bits) is cleared on every state entry.
- **IDLE:**
  - `btn_s` = 1: go to PRESS_WAIT.
  - Otherwise: stay.
- **PRESS_WAIT** (checks in priority order):
  - `btn_s` = 0: go to IDLE. No outputs change.
  - `dcnt` = `DEBOUNCE_CYCLES` − 1: go to PRESSED. Set `btn_pulse` = 1 and `btn_level` = 1. Clear hold counter `hcnt` and `long_done`.
  - Otherwise: `dcnt` + 1.
- **PRESSED:**
  - `btn_s` = 0: go to RELEASE_WAIT.
- **RELEASE_WAIT** (checks in priority order):
  - `btn_s` = 1: go back to PRESSED. No `btn_pulse`; `hcnt` is not cleared.
  - `dcnt` = `DEBOUNCE_CYCLES` − 1: go to IDLE. Clear `btn_level`.
  - Otherwise: `dcnt` + 1.
- **Hold counter `hcnt`:**
  - Increments every cycle in PRESSED or RELEASE_WAIT while `long_done` = 0.
  - When `hcnt` = `LONG_CYCLES` − 1 and `long_done` = 0: set `long_pulse` = 1 for the next cycle, set `long_done` = 1, and freeze `hcnt`.
- **Release:** no pulse of any kind is generated on release.
- **`btn_pulse` and `long_pulse`** return to 0 one cycle after assertion. Neither can stay high for two consecutive cycles.

## Timing
- **Reset values** (asynchronous, all applied immediately):
  - Synchroniser flops = 0.
  - State = IDLE, so `state_dbg` = 00.
  - `dcnt` = 0, `hcnt` = 0, `long_done` = 0.
  - `btn_pulse` = 0, `long_pulse` = 0, `btn_level` = 0.
- **Press latency:**
  - Let E0 be the first edge that samples `btn_raw` = 1, with the input held stable afterwards.
  - `btn_s` = 1 after E1. State becomes PRESS_WAIT at E2.
  - `btn_pulse` and `btn_level` rise at E0 + `DEBOUNCE_CYCLES` + 2. `btn_pulse` falls one edge later.
- **Long press:** `long_pulse` rises at press-confirm edge + `LONG_CYCLES`, provided the button has not been debounced as released by then.
- **Release latency:** with E0 as the first edge sampling 0, `btn_level` falls at E0 + `DEBOUNCE_CYCLES` + 2.
- **Bounce during press:** any 0 in `btn_s` before the window completes restarts qualification from IDLE.
- **Bounce during release:** any 1 in `btn_s` before the window completes returns to PRESSED. `btn_level` stays 1.
- **Reset mid-operation:** all state is lost. If `btn_raw` is still high after reset deasserts, it is treated as a new press with full latency.
- **Counters:** never wrap. `dcnt` is bounded by the state exits; `hcnt` freezes at `LONG_CYCLES` − 1.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES` = 4, `LONG_CYCLES` = 10, `CNT_W` = 8.
1. `btn_raw` held at 1 from E0 for 30 cycles: `btn_pulse` = 1 only in the cycle after E6; `btn_level` = 1 from E6; `long_pulse` = 1 only in the cycle after E16; `state_dbg` = 11.
2. `btn_raw` = 1 for 3 cycles, then 0: no `btn_pulse`, `btn_level` stays 0, `state_dbg` passes 01 and returns to 00.
3. While PRESSED, `btn_raw` = 0 for 2 cycles, then 1: `state_dbg` visits 10 and returns to 11; `btn_level` stays 1; no second `btn_pulse`.
4. Release from PRESSED, `btn_raw` held at 0 from E0: `btn_level` falls at E6; `btn_pulse` and `long_pulse` stay 0.
5. Press, then release 8 cycles after `btn_pulse`: no `long_pulse`; a second press yields exactly one new `btn_pulse`.
6. `reset` asserted in PRESS_WAIT while `btn_raw` = 1: all outputs go to 0 immediately and `state_dbg` = 00. After deassertion with `btn_raw` still 1, `btn_pulse` fires at first post-reset edge + 6.
